// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline chain: perf counter width and
// the popcount helper used for stage occupancy and kill accounting.
package pipe_pkg;

  localparam int PERF_CNT_W = 32;
  // Widest valid vector popcount() accepts; callers zero-extend into it.
  localparam int POP_MAX_W  = 64;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n += {31'b0, bits[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit plus payload register. The stage
// loads when its ready is high, otherwise holds (or drops its valid on kill).
module pipe_stage
  import pipe_pkg::*;
#(
  parameter type payload_t = logic [31:0]
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     kill,
  input  logic     valid_in,
  input  payload_t data_in,
  output logic     valid,
  output payload_t data,
  output logic     valid_nxt
);

  assign valid_nxt = load ? valid_in : (valid && !kill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      // NOTE: the payload is reset as well so out_data reads 0 straight out of reset.
      data  <= '0;
    end else begin
      // NOTE: non-blocking assignments here, so every stage samples its
      // neighbour's pre-edge value and the chain shifts by exactly one.
      valid <= valid_nxt;
      if (load && valid_in) begin
        data <= data_in;
      end
    end
  end

endmodule

// File: rtl/elastic_pipe_chain.sv
// DEPTH-stage elastic register chain with valid/ready on both ends, bubble
// collapse and selective flush. ELASTIC_PIPE_PERF_EN adds stall/kill counters.
module elastic_pipe_chain
  import pipe_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic [CNT_W-1:0]  flush_stage,
  output logic [CNT_W-1:0]  occupancy
`ifdef ELASTIC_PIPE_PERF_EN
  ,
  input  logic                  perf_clr,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_kill_cnt
`endif
);

  typedef logic [DATA_W-1:0] pipe_payload_t;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] load_valid;
  pipe_payload_t    data_q    [DEPTH];
  pipe_payload_t    load_data [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    // Comparing against the raw flush_stage makes values above DEPTH kill everything.
    assign kill[i] = flush && (CNT_W'(i) < flush_stage);
    // Stage i can take new data if any stage from i to the output has a hole.
    assign rdy[i]  = out_ready || !(&v[DEPTH-1:i]);

    if (i == 0) begin : g_entry
      assign load_valid[i] = in_valid && in_ready;
      assign load_data[i]  = in_data;
    end else begin : g_link
      assign load_valid[i] = v[i-1] && !kill[i-1];
      assign load_data[i]  = data_q[i-1];
    end

    pipe_stage #(
      .payload_t (pipe_payload_t)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (rdy[i]),
      .kill      (kill[i]),
      .valid_in  (load_valid[i]),
      .data_in   (load_data[i]),
      .valid     (v[i]),
      .data      (data_q[i]),
      .valid_nxt (v_nxt[i])
    );
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = v[DEPTH-1] && !kill[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  logic [POP_MAX_W-1:0] occ_ext;

  always_comb begin
    // NOTE: full default before the partial write keeps this purely combinational.
    occ_ext              = '0;
    occ_ext[DEPTH-1:0]   = v_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else begin
      occupancy <= CNT_W'(popcount(occ_ext));
    end
  end

`ifdef ELASTIC_PIPE_PERF_EN
  logic [POP_MAX_W-1:0]  killed_ext;
  logic [PERF_CNT_W:0]   stall_sum;
  logic [PERF_CNT_W:0]   kill_sum;

  always_comb begin
    killed_ext            = '0;
    killed_ext[DEPTH-1:0] = v & kill;
    stall_sum = {1'b0, perf_stall_cnt} + (PERF_CNT_W + 1)'(out_valid && !out_ready);
    kill_sum  = {1'b0, perf_kill_cnt}  + (PERF_CNT_W + 1)'(popcount(killed_ext));
  end

  // Carry-out of the widened sum signals overflow; the counters then stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else if (perf_clr) begin
      perf_stall_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      perf_stall_cnt <= stall_sum[PERF_CNT_W] ? '1 : stall_sum[PERF_CNT_W-1:0];
      perf_kill_cnt  <= kill_sum[PERF_CNT_W]  ? '1 : kill_sum[PERF_CNT_W-1:0];
    end
  end
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Directed bench for elastic_pipe_chain (DEPTH=4): expected outputs are queued
// by the stimulus and popped by an independent output monitor.
module tb_elastic_pipe_chain;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [CNT_W-1:0]  flush_stage;
  logic [CNT_W-1:0]  occupancy;
`ifdef ELASTIC_PIPE_PERF_EN
  logic              perf_clr;
  logic [31:0]       perf_stall_cnt;
  logic [31:0]       perf_kill_cnt;
`endif

  elastic_pipe_chain #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .flush       (flush),
    .flush_stage (flush_stage),
    .occupancy   (occupancy)
`ifdef ELASTIC_PIPE_PERF_EN
    ,
    .perf_clr       (perf_clr),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: every handshake consumes the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_extra: got 0x%0h, expected no output (t=%0t)", out_data, $time);
      end else begin
        check("sb_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push four entries with the output blocked; chain ends full, base at stage 3.
  task automatic fill(input logic [DATA_W-1:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = base + DATA_W'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    flush_stage = '0;
`ifdef ELASTIC_PIPE_PERF_EN
    perf_clr    = 1'b0;
`endif
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    #11 rst_n = 1'b1;
    tick();

    // Streaming: data 1..10 at full rate, first output after the 4th edge.
    out_ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      in_valid = (k <= 10);
      in_data  = DATA_W'(k);
      if (k <= 10) exp_q.push_back(DATA_W'(k));
      tick();
      check("stream_out_valid", 32'(out_valid), (k >= 4 && k <= 13) ? 32'd1 : 32'd0);
      check("stream_occupancy", 32'(occupancy), (k <= 10) ? ((k < 4) ? 32'(k) : 32'd4) : 32'(14 - k));
    end
    out_ready = 1'b0;

    // Back-pressure on a full chain, then a single pass-through transfer.
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + 32'(i));
    fill(32'hA0);
    #1;
    check("bp_in_ready",  32'(in_ready),  32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data",  out_data,       32'hA0);
    check("bp_occupancy", 32'(occupancy), 32'd4);
    tick();
    check("bp_hold_data", out_data, 32'hA0);
    out_ready = 1'b1;
    #1;
    check("bp_passthru_ready", 32'(in_ready), 32'd1);
    tick();
    out_ready = 1'b0;
    check("bp_next_data", out_data,       32'hA1);
    check("bp_occ_after", 32'(occupancy), 32'd3);
    drain(4);

    // Bubble collapse: C0 in stage 3, C1 in stage 0, output blocked.
    exp_q.push_back(32'hC0);
    exp_q.push_back(32'hC1);
    in_valid = 1'b1; in_data = 32'hC0; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 32'hC1; tick();
    in_valid = 1'b0;
    check("bub_occ_start", 32'(occupancy), 32'd2);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("bub_occupancy", 32'(occupancy), 32'd2);
      check("bub_in_ready",  32'(in_ready),  32'd1);
      check("bub_out_data",  out_data,       32'hC0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bub_c1_at_out_valid", 32'(out_valid), 32'd1);
    check("bub_c1_at_out_data",  out_data,       32'hC1);
    drain(2);

    // Partial flush: kill stages 0..1 while the output transfers.
    exp_q.push_back(32'hB0);
    exp_q.push_back(32'hB1);
    fill(32'hB0);
    flush = 1'b1; flush_stage = CNT_W'(2); out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hBF;
    #1;
    check("pf_in_ready",  32'(in_ready),  32'd0);
    check("pf_out_valid", 32'(out_valid), 32'd1);
    tick();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("pf_occupancy", 32'(occupancy), 32'd1);
    check("pf_out_data",  out_data,       32'hB1);
    drain(2);
    check("pf_empty", 32'(occupancy), 32'd0);

    // flush_stage 0 is a no-op apart from blocking input; then a full flush.
    exp_q.push_back(32'hD0);
    fill(32'hD0);
    flush = 1'b1; flush_stage = '0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hDF;
    #1;
    check("fs0_in_ready",  32'(in_ready),  32'd0);
    check("fs0_out_valid", 32'(out_valid), 32'd1);
    tick();
    in_valid = 1'b0;
    check("fs0_occupancy", 32'(occupancy), 32'd3);
    flush_stage = CNT_W'(4);
    #1;
    check("ff_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("ff_occupancy",  32'(occupancy), 32'd0);
    check("ff_out_valid2", 32'(out_valid), 32'd0);

    // flush_stage above DEPTH behaves like DEPTH.
    in_valid = 1'b1; in_data = 32'hE0; tick();
    in_data = 32'hE1; tick();
    in_valid = 1'b0;
    check("fs7_occ_before", 32'(occupancy), 32'd2);
    flush = 1'b1; flush_stage = CNT_W'(7);
    tick();
    flush = 1'b0;
    check("fs7_occupancy", 32'(occupancy), 32'd0);

    // Asynchronous reset in the middle of a stream.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hF0 + 32'(k);
      tick();
    end
    check("mid_out_valid", 32'(out_valid), 32'd1);
    check("mid_out_data",  out_data,       32'hF0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  out_data,       32'd0);
    check("arst_occupancy", 32'(occupancy), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_occ",   32'(occupancy), 32'd0);
    check("post_rst_ready", 32'(in_ready),  32'd1);

`ifdef ELASTIC_PIPE_PERF_EN
    exp_q.push_back(32'h60);
    exp_q.push_back(32'h61);
    fill(32'h60);
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    repeat (5) tick();
    check("perf_stall_5", perf_stall_cnt, 32'd5);
    check("perf_kill_0",  perf_kill_cnt,  32'd0);
    flush = 1'b1; flush_stage = CNT_W'(2); out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("perf_kill_2",  perf_kill_cnt,  32'd2);
    check("perf_stall_k", perf_stall_cnt, 32'd5);
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    check("perf_clr_stall", perf_stall_cnt, 32'd0);
    check("perf_clr_kill",  perf_kill_cnt,  32'd0);
    drain(2);
`endif

    repeat (2) tick();
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
